mem_stage: RTL and testbench

- Fourth pipeline stage of the ARC MIPS core. It is the consumer of the EX/MEM pipeline register outputs.
- Resolves branches (PCSrc) and performs loads and stores through a req/ack data-memory handshake.
- Stalls upstream stages while an access is outstanding.
- Registers MEM/WB values for the writeback stage.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_wb_reg.sv | 36 +++
 rtl/mem_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: FSM states, alignment mask and the MEM/WB payload.
package mem_pkg;

   typedef enum logic {IDLE, ACCESS} mem_state_t;

   localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

   typedef struct packed {
      logic        memtoreg;
      logic        regwrite;
      logic [31:0] readdata;
      logic [31:0] alu;
      logic [4:0]  writereg;
   } memwb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears only the WB control bits.
module mem_wb_reg
   import mem_pkg::*;
(
   input  logic   i_clk,
   input  logic   i_rst,
   input  logic   i_load,
   input  logic   i_bubble,
   input  logic   i_loadReadData,
   input  memwb_t i_payload,
   output memwb_t o_payload
);

   memwb_t r_payload;

   // Stores and pass-through ops leave the previous load data in place.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_payload <= '0;
      end else if (i_bubble) begin
         r_payload.memtoreg <= 1'b0;
         r_payload.regwrite <= 1'b0;
      end else if (i_load) begin
         r_payload.memtoreg <= i_payload.memtoreg;
         r_payload.regwrite <= i_payload.regwrite;
         r_payload.alu      <= i_payload.alu;
         r_payload.writereg <= i_payload.writereg;
         if (i_loadReadData) begin
            r_payload.readdata <= i_payload.readdata;
         end
      end
   end

   assign o_payload = r_payload;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, req/ack data-memory access with timeout,
// upstream stall generation and the MEM/WB register.
module mem_stage
   import mem_pkg::*;
#(
   parameter int DMEM_TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_con_mem_branch,
   input  logic        i_con_mem_memread,
   input  logic        i_con_mem_memwrite,
   input  logic        i_con_wb_memtoreg,
   input  logic        i_con_wb_regwrite,
   input  logic [31:0] i_data_AddRst,
   input  logic        i_con_Zero,
   input  logic [31:0] i_data_ALU_Rst,
   input  logic [31:0] i_data_rt,
   input  logic [4:0]  i_addr_MuxRst,
   input  logic        i_con_dmem_ack,
   input  logic [31:0] i_data_dmem_rdata,
   output logic        o_con_dmem_req,
   output logic        o_con_dmem_we,
   output logic [31:0] o_addr_dmem,
   output logic [31:0] o_data_dmem_wdata,
   output logic        o_con_PCSrc,
   output logic [31:0] o_addr_PCBranch,
   output logic        o_con_stall,
   output logic        o_con_mem_err,
   output logic        o_con_wb_memtoreg,
   output logic        o_con_wb_regwrite,
   output logic [31:0] o_data_ReadData,
   output logic [31:0] o_data_ALU_Rst,
   output logic [4:0]  o_addr_WriteReg
);

   localparam int COUNT_W = 8;
   localparam logic [COUNT_W-1:0] LAST_WAIT = COUNT_W'(DMEM_TIMEOUT - 1);

   mem_state_t         r_state;
   mem_state_t         w_nextState;
   logic               r_req;
   logic               r_we;
   logic [31:0]        r_addr;
   logic [31:0]        r_wdata;
   logic [COUNT_W-1:0] r_count;
   logic               r_err;

   logic   w_aligned;
   logic   w_validOp;
   logic   w_illegalOp;
   logic   w_timeoutHit;
   logic   w_stall;
   logic   w_startAccess;
   logic   w_setErr;
   logic   w_wbLoad;
   logic   w_wbBubble;
   logic   w_wbReadData;
   memwb_t w_wbIn;
   memwb_t w_wbOut;

   assign w_aligned    = ((i_data_ALU_Rst[1:0] & WORD_ALIGN_MASK) == 2'b00);
   assign w_validOp    = (i_con_mem_memread ^ i_con_mem_memwrite) & w_aligned;
   assign w_illegalOp  = (i_con_mem_memread | i_con_mem_memwrite) & ~w_validOp;
   assign w_timeoutHit = (r_count == LAST_WAIT);

   // Ack always wins over the timeout, even in the last permitted cycle.
   always_comb begin
      w_nextState   = r_state;
      w_stall       = 1'b0;
      w_startAccess = 1'b0;
      w_setErr      = 1'b0;
      w_wbLoad      = 1'b0;
      w_wbBubble    = 1'b0;
      w_wbReadData  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_validOp) begin
               w_stall       = 1'b1;
               w_startAccess = 1'b1;
               w_wbBubble    = 1'b1;
               w_nextState   = ACCESS;
            end else if (w_illegalOp) begin
               w_setErr   = 1'b1;
               w_wbBubble = 1'b1;
            end else begin
               w_wbLoad = 1'b1;
            end
         end
         ACCESS: begin
            if (i_con_dmem_ack) begin
               w_wbLoad     = 1'b1;
               w_wbReadData = ~r_we;
               w_nextState  = IDLE;
            end else if (w_timeoutHit) begin
               w_setErr    = 1'b1;
               w_wbBubble  = 1'b1;
               w_nextState = IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Request fields are written only on entry to ACCESS so they stay stable while req is high.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_err   <= r_err | w_setErr;
         if (w_startAccess) begin
            r_req   <= 1'b1;
            r_we    <= i_con_mem_memwrite;
            r_addr  <= i_data_ALU_Rst;
            r_wdata <= i_data_rt;
            r_count <= '0;
         end else if (r_state == ACCESS) begin
            if (w_nextState == IDLE) begin
               r_req <= 1'b0;
            end else begin
               r_count <= r_count + COUNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      w_wbIn          = '0;
      w_wbIn.memtoreg = i_con_wb_memtoreg;
      w_wbIn.regwrite = i_con_wb_regwrite;
      w_wbIn.readdata = i_data_dmem_rdata;
      w_wbIn.alu      = i_data_ALU_Rst;
      w_wbIn.writereg = i_addr_MuxRst;
   end

   mem_wb_reg u_memWb (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_load         (w_wbLoad),
      .i_bubble       (w_wbBubble),
      .i_loadReadData (w_wbReadData),
      .i_payload      (w_wbIn),
      .o_payload      (w_wbOut)
   );

   assign o_con_dmem_req    = r_req;
   assign o_con_dmem_we     = r_we;
   assign o_addr_dmem       = r_addr;
   assign o_data_dmem_wdata = r_wdata;
   assign o_con_stall       = w_stall;
   assign o_con_mem_err     = r_err;
   assign o_con_PCSrc       = i_con_mem_branch & i_con_Zero & ~w_stall;
   assign o_addr_PCBranch   = i_data_AddRst;
   assign o_con_wb_memtoreg = w_wbOut.memtoreg;
   assign o_con_wb_regwrite = w_wbOut.regwrite;
   assign o_data_ReadData   = w_wbOut.readdata;
   assign o_data_ALU_Rst    = w_wbOut.alu;
   assign o_addr_WriteReg   = w_wbOut.writereg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the stage.
module tb_mem_stage;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        branch, memread, memwrite, memtoreg, regwrite, zero, ack;
   logic [31:0] addRst, aluRst, rt, rdata;
   logic [4:0]  muxRst;

   logic        oReq, oWe, oPcSrc, oStall, oErr, oMemtoreg, oRegwrite;
   logic [31:0] oAddr, oWdata, oPcBranch, oReadData, oAlu;
   logic [4:0]  oWriteReg;

   always #5 clk = ~clk;

   mem_stage #(.DMEM_TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_con_mem_branch(branch), .i_con_mem_memread(memread), .i_con_mem_memwrite(memwrite),
      .i_con_wb_memtoreg(memtoreg), .i_con_wb_regwrite(regwrite),
      .i_data_AddRst(addRst), .i_con_Zero(zero), .i_data_ALU_Rst(aluRst),
      .i_data_rt(rt), .i_addr_MuxRst(muxRst),
      .i_con_dmem_ack(ack), .i_data_dmem_rdata(rdata),
      .o_con_dmem_req(oReq), .o_con_dmem_we(oWe), .o_addr_dmem(oAddr),
      .o_data_dmem_wdata(oWdata), .o_con_PCSrc(oPcSrc), .o_addr_PCBranch(oPcBranch),
      .o_con_stall(oStall), .o_con_mem_err(oErr),
      .o_con_wb_memtoreg(oMemtoreg), .o_con_wb_regwrite(oRegwrite),
      .o_data_ReadData(oReadData), .o_data_ALU_Rst(oAlu), .o_addr_WriteReg(oWriteReg)
   );

   int checks = 0;
   int passes = 0;

   // Behavioural model state
   bit          mBusy;
   int          mWaited;
   bit          mErr, mReq, mWe, mMemtoreg, mRegwrite;
   logic [31:0] mAddr, mWdata, mReadData, mAlu;
   logic [4:0]  mWriteReg;
   bit          expStall, expPcSrc;
   bit          obsStall, obsReq;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
   endtask

   function automatic void modelReset();
      mBusy = 0; mWaited = 0; mErr = 0; mReq = 0; mWe = 0;
      mAddr = '0; mWdata = '0; mMemtoreg = 0; mRegwrite = 0;
      mReadData = '0; mAlu = '0; mWriteReg = '0;
   endfunction

   function automatic void modelComb();
      bit valid;
      valid = (memread != memwrite) && (aluRst % 4 == 0);
      if (!mBusy) expStall = valid;
      else        expStall = !ack && (mWaited != TIMEOUT - 1);
      expPcSrc = branch && zero && !expStall;
   endfunction

   function automatic void modelNext();
      bit valid, illegal;
      valid   = (memread != memwrite) && (aluRst % 4 == 0);
      illegal = (memread || memwrite) && !valid;
      if (rst) begin
         modelReset();
      end else if (!mBusy) begin
         if (valid) begin
            mBusy = 1; mWaited = 0; mReq = 1; mWe = memwrite; mAddr = aluRst; mWdata = rt;
            mMemtoreg = 0; mRegwrite = 0;
         end else if (illegal) begin
            mErr = 1; mMemtoreg = 0; mRegwrite = 0;
         end else begin
            mMemtoreg = memtoreg; mRegwrite = regwrite; mAlu = aluRst; mWriteReg = muxRst;
         end
      end else if (ack) begin
         mBusy = 0; mReq = 0;
         mMemtoreg = memtoreg; mRegwrite = regwrite; mAlu = aluRst; mWriteReg = muxRst;
         if (!mWe) mReadData = rdata;
      end else if (mWaited == TIMEOUT - 1) begin
         mBusy = 0; mReq = 0; mErr = 1; mMemtoreg = 0; mRegwrite = 0;
      end else begin
         mWaited++;
      end
   endfunction

   // One clock: check everything at the falling edge, advance the model, return just after the rising edge.
   task automatic stepCycle();
      @(negedge clk);
      modelComb();
      obsStall = oStall;
      obsReq   = oReq;
      checkOutput("stall", oStall, expStall);
      checkOutput("pcsrc", oPcSrc, expPcSrc);
      checkOutput("pcbranch", oPcBranch, addRst);
      checkOutput("req", oReq, mReq);
      checkOutput("err", oErr, mErr);
      checkOutput("wb_regwrite", oRegwrite, mRegwrite);
      checkOutput("wb_memtoreg", oMemtoreg, mMemtoreg);
      if (mReq) begin
         checkOutput("we", oWe, mWe);
         checkOutput("addr", oAddr, mAddr);
         checkOutput("wdata", oWdata, mWdata);
      end
      checkOutput("readdata", oReadData, mReadData);
      checkOutput("wb_alu", oAlu, mAlu);
      checkOutput("wb_writereg", oWriteReg, mWriteReg);
      modelNext();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic br, input logic rd, input logic wr, input logic m2r,
                                input logic rw, input logic [31:0] addr, input logic z,
                                input logic [31:0] alu, input logic [31:0] data, input logic [4:0] dst);
      branch = br; memread = rd; memwrite = wr; memtoreg = m2r; regwrite = rw;
      addRst = addr; zero = z; aluRst = alu; rt = data; muxRst = dst;
   endtask

   int stallCount;
   int reqCount;

   initial begin
      rst = 1'b1; ack = 1'b0; rdata = '0;
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0);
      modelReset();
      @(posedge clk); #1;
      stepCycle();
      checkOutput("reset_err", oErr, 32'd0);
      checkOutput("reset_req", oReq, 32'd0);
      rst = 1'b0;

      // ALU pass-through
      applyStimulus(0, 0, 0, 0, 1, 32'h0, 0, 32'h10, 32'h0, 5'd5);
      stepCycle();
      checkOutput("alu_pass_result", oAlu, 32'h10);
      checkOutput("alu_pass_dst", oWriteReg, 32'd5);
      checkOutput("alu_pass_rw", oRegwrite, 32'd1);

      // Load with ack held high: two cycles
      applyStimulus(0, 1, 0, 1, 1, 32'h0, 0, 32'h40, 32'h0, 5'd7);
      ack = 1'b1; rdata = 32'hDEADBEEF;
      stepCycle();
      checkOutput("load_req", oReq, 32'd1);
      checkOutput("load_addr", oAddr, 32'h40);
      stepCycle();
      checkOutput("load_data", oReadData, 32'hDEADBEEF);
      checkOutput("load_m2r", oMemtoreg, 32'd1);
      ack = 1'b0;

      // Store acked in the last permitted ACCESS cycle
      applyStimulus(0, 0, 1, 0, 0, 32'h0, 0, 32'h80, 32'h1234, 5'd0);
      stallCount = 0;
      for (int i = 0; i < 4; i++) begin
         stepCycle();
         stallCount += int'(obsStall);
      end
      ack = 1'b1;
      stepCycle();
      stallCount += int'(obsStall);
      ack = 1'b0;
      checkOutput("store_stall_cycles", stallCount, 32'd4);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0);
      stepCycle();

      // Misaligned load
      applyStimulus(0, 1, 0, 1, 1, 32'h0, 0, 32'h41, 32'h0, 5'd3);
      stepCycle();
      checkOutput("misalign_err", oErr, 32'd1);
      checkOutput("misalign_req", oReq, 32'd0);
      checkOutput("misalign_rw", oRegwrite, 32'd0);
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0);
      stepCycle();
      rst = 1'b0;

      // Load that never gets an ack
      applyStimulus(0, 1, 0, 1, 1, 32'h0, 0, 32'h100, 32'h0, 5'd9);
      reqCount = 0;
      for (int i = 0; i < 5; i++) begin
         stepCycle();
         reqCount += int'(obsReq);
      end
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0);
      stepCycle();
      reqCount += int'(obsReq);
      checkOutput("timeout_req_cycles", reqCount, TIMEOUT);
      checkOutput("timeout_err", oErr, 32'd1);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("timeout_err_cleared", oErr, 32'd0);

      // Branch resolution
      applyStimulus(1, 0, 0, 0, 0, 32'h200, 1, 32'h0, 32'h0, 5'd0);
      #1;
      checkOutput("branch_taken", oPcSrc, 32'd1);
      checkOutput("branch_target", oPcBranch, 32'h200);
      stepCycle();
      zero = 1'b0;
      #1;
      checkOutput("branch_not_taken", oPcSrc, 32'd0);
      stepCycle();

      // Reset in the middle of ACCESS, then a late ack
      applyStimulus(0, 1, 0, 1, 1, 32'h0, 0, 32'h60, 32'h0, 5'd4);
      stepCycle();
      stepCycle();
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0);
      ack = 1'b1; rdata = 32'hCAFEF00D;
      stepCycle();
      checkOutput("late_ack_req", oReq, 32'd0);
      checkOutput("late_ack_data", oReadData, 32'd0);
      ack = 1'b0;

      // Randomized traffic; upstream holds its instruction while stalled
      for (int n = 0; n < 400; n++) begin
         if (!expStall) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            applyStimulus($urandom_range(0, 1), 0, 0, $urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom, $urandom_range(0, 1), $urandom, $urandom, 5'($urandom));
            case (kind)
               3, 4: begin memread = 1; aluRst[1:0] = 2'b00; end
               5, 6: begin memwrite = 1; aluRst[1:0] = 2'b00; end
               7: begin
                  if ($urandom_range(0, 1) == 1) memread = 1; else memwrite = 1;
                  if (aluRst[1:0] == 2'b00) aluRst[0] = 1'b1;
               end
               8: begin memread = 1; memwrite = 1; end
               default: ;
            endcase
         end
         ack   = ($urandom_range(0, 3) == 0);
         rdata = $urandom;
         rst   = ($urandom_range(0, 99) == 0);
         stepCycle();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
